// File: rtl/mpe_result_wb_if.sv
// NRAM line-write bus of the matrix-PE result write-back stage.
// master drives the line and its valid; slave returns ready.
interface mpe_result_wb_if #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 12
);
    logic [LANES*32-1:0] wb_nram_data;
    logic [LANES-1:0]    wb_nram_mask;
    logic [ADDR_W-1:0]   wb_nram_addr;
    logic                wb_nram_valid;
    logic                wb_nram_ready;

    modport master (
        output wb_nram_data,
        output wb_nram_mask,
        output wb_nram_addr,
        output wb_nram_valid,
        input  wb_nram_ready
    );

    modport slave (
        input  wb_nram_data,
        input  wb_nram_mask,
        input  wb_nram_addr,
        input  wb_nram_valid,
        output wb_nram_ready
    );
endinterface

// File: rtl/mpe_result_wb.sv
// Packs PE dot-product results into NRAM lines and writes them through a 2-entry FIFO.
// Optional MPE_WB_RELU_EN: negative results are replaced by zero before packing.
module mpe_result_wb #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mpe_result,
    input  logic              mpe_result_vld,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic              flush,
    mpe_result_wb_if.master   wb,
    output logic              busy,
    output logic              overflow
);
    localparam int LP_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LINE_W = LANES * 32;

    logic [31:0] result_in;
`ifdef MPE_WB_RELU_EN
    assign result_in = mpe_result[31] ? 32'd0 : mpe_result;
`else
    assign result_in = mpe_result;
`endif

    // Assembly state
    logic [LINE_W-1:0] asm_data_reg, asm_data_next;
    logic [LANES-1:0]  asm_mask_reg, asm_mask_next;
    logic [LP_W-1:0]   lp_reg, lp_next;
    logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
    logic              overflow_reg, overflow_next;
    logic              busy_reg, busy_next;

    // Two-entry FIFO: head feeds the NRAM bus, tail is the second slot
    logic [LINE_W-1:0] head_data_reg, head_data_next, tail_data_reg, tail_data_next;
    logic [LANES-1:0]  head_mask_reg, head_mask_next, tail_mask_reg, tail_mask_next;
    logic [ADDR_W-1:0] head_addr_reg, head_addr_next, tail_addr_reg, tail_addr_next;
    logic [1:0]        count_reg, count_next;

    logic [LP_W-1:0]   base_lp;
    logic [LANES-1:0]  lane_hit;
    logic [LINE_W-1:0] line_data;
    logic [LANES-1:0]  line_mask;
    logic [ADDR_W-1:0] line_addr;
    logic              line_full;
    logic              push;
    logic              push_ok;
    logic              drop;
    logic              pop;

    // cfg_start discards the partial line before this cycle's result lands
    assign base_lp   = cfg_start ? '0 : lp_reg;
    assign line_addr = cfg_start ? cfg_base_addr : addr_ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi] = mpe_result_vld && (base_lp == LP_W'(gi));
            assign line_data[gi*32 +: 32] = lane_hit[gi] ? result_in :
                                            (cfg_start ? 32'd0 : asm_data_reg[gi*32 +: 32]);
            assign line_mask[gi] = lane_hit[gi] | (~cfg_start & asm_mask_reg[gi]);
        end
    endgenerate

    assign line_full = mpe_result_vld && (base_lp == LP_W'(LANES - 1));
    assign push      = line_full || (flush && (|line_mask));
    assign pop       = wb.wb_nram_valid && wb.wb_nram_ready;
    // A full FIFO still accepts a push when its head leaves in the same cycle
    assign push_ok   = push && ((count_reg != 2'd2) || pop);
    assign drop      = push && !push_ok;

    always_comb begin
        asm_data_next = push ? '0 : line_data;
        asm_mask_next = push ? '0 : line_mask;
        lp_next       = base_lp;
        if (push)
            lp_next = '0;
        else if (mpe_result_vld)
            lp_next = base_lp + LP_W'(1);
        addr_ptr_next = push_ok ? line_addr + ADDR_W'(1) : line_addr;
        overflow_next = (overflow_reg & ~cfg_start) | drop;
        count_next    = count_reg + 2'(push_ok) - 2'(pop);
        busy_next     = (|asm_mask_next) || (count_next != 2'd0);
    end

    always_comb begin
        head_data_next = head_data_reg;
        head_mask_next = head_mask_reg;
        head_addr_next = head_addr_reg;
        tail_data_next = tail_data_reg;
        tail_mask_next = tail_mask_reg;
        tail_addr_next = tail_addr_reg;
        // Head advances from the tail when both are occupied, else from the new line
        if (pop && count_reg == 2'd2) begin
            head_data_next = tail_data_reg;
            head_mask_next = tail_mask_reg;
            head_addr_next = tail_addr_reg;
            if (push_ok) begin
                tail_data_next = line_data;
                tail_mask_next = line_mask;
                tail_addr_next = line_addr;
            end
        end else if (push_ok) begin
            if (pop || count_reg == 2'd0) begin
                head_data_next = line_data;
                head_mask_next = line_mask;
                head_addr_next = line_addr;
            end else begin
                tail_data_next = line_data;
                tail_mask_next = line_mask;
                tail_addr_next = line_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_data_reg  <= '0;
            asm_mask_reg  <= '0;
            lp_reg        <= '0;
            addr_ptr_reg  <= '0;
            overflow_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            count_reg     <= 2'd0;
            head_data_reg <= '0;
            head_mask_reg <= '0;
            head_addr_reg <= '0;
            tail_data_reg <= '0;
            tail_mask_reg <= '0;
            tail_addr_reg <= '0;
        end else begin
            asm_data_reg  <= asm_data_next;
            asm_mask_reg  <= asm_mask_next;
            lp_reg        <= lp_next;
            addr_ptr_reg  <= addr_ptr_next;
            overflow_reg  <= overflow_next;
            busy_reg      <= busy_next;
            count_reg     <= count_next;
            head_data_reg <= head_data_next;
            head_mask_reg <= head_mask_next;
            head_addr_reg <= head_addr_next;
            tail_data_reg <= tail_data_next;
            tail_mask_reg <= tail_mask_next;
            tail_addr_reg <= tail_addr_next;
        end
    end

    assign wb.wb_nram_data  = head_data_reg;
    assign wb.wb_nram_mask  = head_mask_reg;
    assign wb.wb_nram_addr  = head_addr_reg;
    assign wb.wb_nram_valid = (count_reg != 2'd0);
    assign busy             = busy_reg;
    assign overflow         = overflow_reg;
endmodule

// File: doc/mpe_result_wb.md
# mpe_result_wb

Write-back stage directly downstream of the matrix PE. It captures the 32-bit dot-product results the PE emits one per `vld_o` pulse and packs them into 512-bit NRAM lines. It buffers up to two completed lines and writes each line to NRAM through a valid/ready handshake with an auto-incrementing line address. The PE has no output backpressure, so this block absorbs results unconditionally and flags any loss.

## Interface
Parameters:
- `LANES`, 16, 32-bit results per NRAM line; fixed so that `LANES*32 = 512`.
- `ADDR_W`, 12, width of the NRAM line address.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mpe_result`  in  32  signed result from the PE.
- `mpe_result_vld`  in  1  `mpe_result` is valid this cycle; there is no ready.
- `cfg_start`  in  1  one-cycle pulse that begins a new output block.
- `cfg_base_addr`  in  ADDR_W  first line address, sampled on `cfg_start`.
- `flush`  in  1  one-cycle pulse that emits a partially filled line.
- `wb_nram_data`  out  512  packed line; lane i occupies bits [32i+31:32i].
- `wb_nram_mask`  out  LANES  bit i set means lane i holds a real result.
- `wb_nram_addr`  out  ADDR_W  line address for this write.
- `wb_nram_valid`  out  1  a write request is pending.
- `wb_nram_ready`  in  1  NRAM accepts the write.
- `busy`  out  1  high when a partial line exists or the FIFO is non-empty.
- `overflow`  out  1  sticky; set when a line was dropped.

## Operation
- Assembly register holds `LANES` x 32-bit lanes, a lane pointer `lp` (0..LANES-1), and a fill mask.
- On `mpe_result_vld`:
  - The result (ReLU-filtered if enabled) is written to lane `lp`, its mask bit is set, and `lp` increments.
  - When `lp == LANES-1`, the line is complete: push {data, mask, `addr_ptr`} into a 2-entry FIFO, then clear `lp` and the mask.
- `flush` with `lp > 0` pushes the partial line. Unfilled lanes are zero and their mask bits are 0.
- `flush` in the same cycle as `mpe_result_vld`:
  - The result is placed first.
  - If that result completes the line, a single full-line push occurs. Otherwise the partial line, including the new result, is pushed.
  - `flush` with `lp == 0` and no result is a no-op.
- `addr_ptr` increments by 1 on every successful push and wraps modulo 2^ADDR_W.
- Push with the FIFO full and no pop in the same cycle:
  - The line is dropped and `overflow` is set.
  - `addr_ptr` does not increment.
  - `lp` and the mask still clear.
- Push and pop in the same cycle with the FIFO full: both succeed and no overflow occurs.
- `cfg_start`:
  - Loads `addr_ptr` from `cfg_base_addr`, clears `lp`, the mask and `overflow`. Any partial line is discarded.
  - FIFO contents are kept and still drain.
  - A result arriving in the same cycle is written to lane 0.
- The FIFO head drives `wb_nram_*` directly from registers. Pop on `wb_nram_valid && wb_nram_ready`.

## Timing
- Reset values: `wb_nram_data`=0, `wb_nram_mask`=0, `wb_nram_addr`=0, `wb_nram_valid`=0, `busy`=0, `overflow`=0. `addr_ptr`=0, `lp`=0, FIFO empty.
- Latency: a line completed or flushed in cycle N gives `wb_nram_valid`=1 in cycle N+1 when the FIFO was empty.
- `wb_nram_data`, `wb_nram_mask` and `wb_nram_addr` hold stable while `valid && !ready`.
- `valid` deasserts only after acceptance.
- Sustained throughput: one result per cycle, with `ready` high at least 1/LANES of cycles, is lossless.
- `overflow` updates in the cycle after the dropped push.
- `busy` is registered and reflects state after each edge.
- Reset mid-operation immediately clears all state, and any in-flight write request is abandoned.

## Configuration
- `MPE_WB_RELU_EN` defined: each incoming result with bit 31 set is replaced by 0 before packing. Mask bits are unaffected.
- Not defined: results pass unmodified, and the ReLU logic is absent from the netlist.

## Test plan
- Reset, `cfg_start` with base 0x010, 16 results 0x1..0x10 on consecutive cycles, `ready`=1:
  - One write at addr 0x010 with mask 0xFFFF, lane0=0x1 and lane15=0x10.
  - `valid` asserts the cycle after the 16th result.
- 3 results (0xA, 0xB, 0xC), then `flush`: write with mask 0x0007, lanes 3..15 zero. `flush` in a later cycle with nothing pending gives no write.
- `ready`=0 while 48 results arrive:
  - Two lines are buffered and the third is dropped.
  - `overflow`=1 and the address advances by 2 only.
  - `cfg_start` clears `overflow`.
- `cfg_base_addr`=2^ADDR_W-1 and 32 results: writes at 0xFFF then 0x000.
- Result -5 (0xFFFFFFFB) in lane 0: packed as 0 with `MPE_WB_RELU_EN`, and as 0xFFFFFFFB without it.
- Assert `rst_n` low while `valid`=1 and `lp`=7:
  - All outputs are 0 immediately.
  - After release, 16 results produce one full line at addr 0.
